tcp_flowid_alloc: RTL

Free-list allocator that owns the TCP flow-ID space and hands IDs to the RX new-flow controller on SYN acceptance. Freed IDs are taken back from the connection-teardown path. The block sits beside the slow-path controller. It supplies the `flowid_avail` / `flowid_manager_req` pair and the ID that the controller latches on `slow_path_store_flowid`.

---
 rtl/tcp_flowid_pkg.sv | 7 +
 rtl/flowid_free_fifo.sv | 26 ++
 rtl/tcp_flowid_alloc.sv | 58 +++++
 3 files changed

// File: rtl/tcp_flowid_pkg.sv
// tcp_flowid_pkg: shared flow-ID widths, ID type and allocator state encoding.
package tcp_flowid_pkg;
  localparam int FLOWID_W = 3;
  localparam int NUM_FLOWS = 2 ** FLOWID_W;
  typedef logic [FLOWID_W-1:0] flowid_t;
  typedef enum logic {INIT, RUN} alloc_state_e;
endpackage

// File: rtl/flowid_free_fifo.sv
// flowid_free_fifo: circular store of free IDs, one write port, async read of the head.
module flowid_free_fifo #(
  parameter int W = 3,
  parameter int N = 2 ** W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data
);
  logic [W-1:0] mem [N];
  logic [W-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/tcp_flowid_alloc.sv
// tcp_flowid_alloc: free-list allocator of TCP flow IDs with init fill, recycle and double-free detection.
module tcp_flowid_alloc #(
  parameter int FLOWID_W = 3,
  parameter int NUM_FLOWS = 2 ** FLOWID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flowid_manager_req,
  output logic                flowid_avail,
  output logic [FLOWID_W-1:0] flowid,
  input  logic                free_val,
  input  logic [FLOWID_W-1:0] free_flowid,
  output logic                free_rdy,
  output logic [FLOWID_W:0]   flows_in_use,
  output logic                double_free_err
);
  import tcp_flowid_pkg::*;
  localparam logic [FLOWID_W:0] FULL = (FLOWID_W+1)'(NUM_FLOWS);
  localparam logic [FLOWID_W-1:0] LAST = FLOWID_W'(NUM_FLOWS - 1);
  alloc_state_e state, state_nx;
  logic [FLOWID_W-1:0] init_idx, head, wr_data;
  logic [FLOWID_W:0] free_cnt;
  logic [NUM_FLOWS-1:0] in_use;
  logic run, alloc, free_hit, free_miss, wr_en;
  flowid_free_fifo #(.W(FLOWID_W), .N(NUM_FLOWS)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(alloc), .rd_data(head)
  );
  // The bitmap is consulted before this cycle's alloc, so freeing the ID being handed out counts as a double free.
  always_comb begin
    run = state == RUN;
    flowid_avail = run && free_cnt != '0;
    free_rdy = run;
    alloc = flowid_manager_req && flowid_avail;
    free_hit = free_val && run && in_use[free_flowid];
    free_miss = free_val && run && !in_use[free_flowid];
    wr_en = !run || free_hit;
    wr_data = run ? free_flowid : init_idx;
    state_nx = (!run && init_idx == LAST) ? RUN : state;
    flowid = run ? head : '0;
    flows_in_use = run ? FULL - free_cnt : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      init_idx <= '0;
      free_cnt <= '0;
      in_use <= '0;
      double_free_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (!run) init_idx <= init_idx + 1'b1;
      if (!run && state_nx == RUN) free_cnt <= FULL;
      else if (run) free_cnt <= free_cnt + (FLOWID_W+1)'(free_hit) - (FLOWID_W+1)'(alloc);
      if (free_hit) in_use[free_flowid] <= 1'b0;
      if (alloc) in_use[head] <= 1'b1;
      double_free_err <= double_free_err | free_miss;
    end
endmodule
